// File: rtl/regmap_access_arbiter.sv
// regmap_access_arbiter
//
// Two-port arbiter in front of the register map's single access port.
// Port 0 is the SPI slave memory interface (already in the clk_i domain)
// and port 1 is the on-chip sequencer. An accepted request becomes a
// one-cycle read or write strobe. A read then waits READ_LATENCY cycles
// for read_data_i. A one-cycle completion pulse goes back to the port
// that issued the request. Writes to status addresses (addr >=
// NUM_CONFIG_REG) are dropped and are reported with rspk_err_o.
//
// Ports (k = 0, 1):
//   clk_i, rstn_n           clock, asynchronous active-low reset
//   reqk_valid_i/ready_o    request handshake (ready is combinational)
//   reqk_we_i/addr_i/wdata_i request fields, held stable until accepted
//   rspk_valid_o/rdata_o/err_o  registered one-cycle completion
//   addr_o, write_data_o    register map address / write data (held)
//   write_en_o, read_en_o   one-cycle register map strobes
//   read_data_i             register map read data
//   busy_o                  high whenever the FSM is not idle
//   last_grant_o            index of the most recently accepted port

module regmap_access_arbiter #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CONFIG_REG = 96,
    parameter int READ_LATENCY   = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_n,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
    output logic                  rsp0_err_o,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
    output logic                  rsp1_err_o,

    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  busy_o,
    output logic                  last_grant_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    localparam logic [1:0]          LAT       = 2'(READ_LATENCY);
    // One extra bit so NUM_CONFIG_REG == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] CFG_LIMIT = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG);

    // ------------------------------------------------------------------
    // Requests gathered into arrays so the grant index can select them
    // ------------------------------------------------------------------
    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];

    assign req_valid    = {req1_valid_i, req0_valid_i};
    assign req_we       = {req1_we_i, req0_we_i};
    assign req_addr[0]  = req0_addr_i;
    assign req_addr[1]  = req1_addr_i;
    assign req_wdata[0] = req0_wdata_i;
    assign req_wdata[1] = req1_wdata_i;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  last_grant_q, last_grant_d;   // also the in-flight port
    logic                  req_we_q, req_we_d;
    logic                  err_q, err_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_en_q, write_en_d;
    logic                  read_en_q, read_en_d;
    logic                  busy_q, busy_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q [2];
    logic [DATA_WIDTH-1:0] rsp_rdata_d [2];

    // ------------------------------------------------------------------
    // Selection: a lone valid wins, a tie goes to the round-robin pointer
    // ------------------------------------------------------------------
    logic sel;
    logic accept;

    always_comb begin
        sel = ptr_q;
        if (req_valid == 2'b01) begin
            sel = 1'b0;
        end else if (req_valid == 2'b10) begin
            sel = 1'b1;
        end
    end

    assign accept       = (state_q == S_IDLE) && req_valid[sel];
    assign req0_ready_o = (state_q == S_IDLE) && req_valid[0] && (sel == 1'b0);
    assign req1_ready_o = (state_q == S_IDLE) && req_valid[1] && (sel == 1'b1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_n) begin
        if (!rstn_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_CMD;
            S_CMD:   state_d = (!req_we_q && (LAT != 2'd0)) ? S_WAIT : S_RSP;
            S_WAIT:  if (cnt_q == LAT) state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Every output is registered, so the values for the
    // next cycle are computed here from the current state and the
    // transition being taken.
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d          = ptr_q;
        last_grant_d   = last_grant_q;
        req_we_d       = req_we_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        write_en_d     = 1'b0;
        read_en_d      = 1'b0;
        busy_d         = (state_d != S_IDLE);
        rsp_valid_d    = 2'b00;
        rsp_err_d      = 2'b00;
        rsp_rdata_d[0] = '0;
        rsp_rdata_d[1] = '0;

        if (accept) begin
            // Latch the request and arm the strobe for the CMD cycle.
            ptr_d        = ~sel;
            last_grant_d = sel;
            req_we_d     = req_we[sel];
            addr_d       = req_addr[sel];
            wdata_d      = req_wdata[sel];
            err_d        = req_we[sel] && ({1'b0, req_addr[sel]} >= CFG_LIMIT);
            write_en_d   = req_we[sel] && ({1'b0, req_addr[sel]} < CFG_LIMIT);
            read_en_d    = !req_we[sel];
            cnt_d        = 2'd1;
        end

        if (state_q == S_WAIT && state_d == S_WAIT) begin
            cnt_d = cnt_q + 2'd1;
        end

        // Entering RSP is also the read-data capture cycle: the last WAIT
        // cycle, or the CMD cycle itself for writes and zero latency.
        if (state_d == S_RSP && state_q != S_RSP) begin
            rsp_valid_d[last_grant_q] = 1'b1;
            rsp_err_d[last_grant_q]   = err_q;
            rsp_rdata_d[last_grant_q] = req_we_q ? '0 : read_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_n) begin
        if (!rstn_n) begin
            ptr_q          <= 1'b0;
            last_grant_q   <= 1'b0;
            req_we_q       <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= 2'd0;
            addr_q         <= '0;
            wdata_q        <= '0;
            write_en_q     <= 1'b0;
            read_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            rsp_valid_q    <= 2'b00;
            rsp_err_q      <= 2'b00;
            rsp_rdata_q[0] <= '0;
            rsp_rdata_q[1] <= '0;
        end else begin
            ptr_q          <= ptr_d;
            last_grant_q   <= last_grant_d;
            req_we_q       <= req_we_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            write_en_q     <= write_en_d;
            read_en_q      <= read_en_d;
            busy_q         <= busy_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_rdata_q[0] <= rsp_rdata_d[0];
            rsp_rdata_q[1] <= rsp_rdata_d[1];
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign addr_o       = addr_q;
    assign write_data_o = wdata_q;
    assign write_en_o   = write_en_q;
    assign read_en_o    = read_en_q;
    assign busy_o       = busy_q;
    assign last_grant_o = last_grant_q;
    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp0_err_o   = rsp_err_q[0];
    assign rsp0_rdata_o = rsp_rdata_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp1_err_o   = rsp_err_q[1];
    assign rsp1_rdata_o = rsp_rdata_q[1];

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// Testbench for regmap_access_arbiter. Three instances run side by side
// with READ_LATENCY = 1, 0 and 3; each has its own register map model
// that drives read_data_i only in the cycle the data is due (0xEE
// otherwise), so a capture in the wrong cycle shows up as wrong data.

module tb_regmap_access_arbiter;

    localparam int NI = 3;

    logic clk;
    logic rstn_n;
    int   cyc;
    int   chk_cnt;
    int   err_cnt;

    logic       req_valid [NI][2];
    logic       req_we    [NI][2];
    logic [6:0] req_addr  [NI][2];
    logic [7:0] req_wdata [NI][2];
    logic       req_ready [NI][2];
    logic       rsp_valid [NI][2];
    logic       rsp_err   [NI][2];
    logic [7:0] rsp_rdata [NI][2];

    logic [NI-1:0] write_en;
    logic [NI-1:0] read_en;
    logic [NI-1:0] busy;
    logic [NI-1:0] last_grant;
    logic [6:0]    addr_o     [NI];
    logic [7:0]    write_data [NI];
    logic [7:0]    rd_data    [NI];

    logic [7:0] mem_data [NI][128];
    logic       mem_wr   [NI][128];
    logic [2:0] age      [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rstn_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    // Power-on contents of the modelled register maps.
    function automatic logic [7:0] init_val(input int i, input logic [6:0] a);
        if (i == 0 && a == 7'd100) return 8'h3C;
        if (i == 0 && a == 7'd96)  return 8'hD6;
        if (i == 1 && a == 7'd20)  return 8'h81;
        if (i == 2 && a == 7'd21)  return 8'h42;
        if (i == 2 && a == 7'd22)  return 8'h99;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rstn_n) begin
                age[i] <= 3'd0;
                for (int a = 0; a < 128; a++) mem_wr[i][a] <= 1'b0;
            end else begin
                if (write_en[i]) begin
                    mem_wr[i][addr_o[i]]   <= 1'b1;
                    mem_data[i][addr_o[i]] <= write_data[i];
                end
                if (read_en[i])                         age[i] <= 3'd1;
                else if (age[i] != 3'd0 && age[i] != 3'd7) age[i] <= age[i] + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

            assign rd_data[gi] = ((L == 0 && read_en[gi]) || (L != 0 && age[gi] == 3'(L)))
                               ? (mem_wr[gi][addr_o[gi]] ? mem_data[gi][addr_o[gi]]
                                                         : init_val(gi, addr_o[gi]))
                               : 8'hEE;

            regmap_access_arbiter #(
                .ADDR_WIDTH    (7),
                .DATA_WIDTH    (8),
                .NUM_CONFIG_REG(96),
                .READ_LATENCY  (L)
            ) u_dut (
                .clk_i        (clk),
                .rstn_n       (rstn_n),
                .req0_valid_i (req_valid[gi][0]),
                .req0_ready_o (req_ready[gi][0]),
                .req0_we_i    (req_we[gi][0]),
                .req0_addr_i  (req_addr[gi][0]),
                .req0_wdata_i (req_wdata[gi][0]),
                .rsp0_valid_o (rsp_valid[gi][0]),
                .rsp0_rdata_o (rsp_rdata[gi][0]),
                .rsp0_err_o   (rsp_err[gi][0]),
                .req1_valid_i (req_valid[gi][1]),
                .req1_ready_o (req_ready[gi][1]),
                .req1_we_i    (req_we[gi][1]),
                .req1_addr_i  (req_addr[gi][1]),
                .req1_wdata_i (req_wdata[gi][1]),
                .rsp1_valid_o (rsp_valid[gi][1]),
                .rsp1_rdata_o (rsp_rdata[gi][1]),
                .rsp1_err_o   (rsp_err[gi][1]),
                .addr_o       (addr_o[gi]),
                .write_data_o (write_data[gi]),
                .write_en_o   (write_en[gi]),
                .read_en_o    (read_en[gi]),
                .read_data_i  (rd_data[gi]),
                .busy_o       (busy[gi]),
                .last_grant_o (last_grant[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on instance i, port k, checked cycle by
    // cycle from the acceptance cycle T through the return to idle.
    task automatic run_txn(input int i, input int k, input logic we,
                           input logic [6:0] addr, input logic [7:0] wd,
                           input logic exp_wen, input logic [7:0] exp_rd,
                           input logic exp_err);
        int n;
        int lat;
        lat = we ? 0 : lat_of(i);
        req_we[i][k]    = we;
        req_addr[i][k]  = addr;
        req_wdata[i][k] = wd;
        req_valid[i][k] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[i][k] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready[i][k]) begin
            chk("accept_timeout", 32'(0), 32'(1));
            req_valid[i][k] = 1'b0;
            return;
        end
        // T+1: the command cycle.
        @(negedge clk);
        req_valid[i][k] = 1'b0;
        #1;
        chk("cmd_write_en", 32'(write_en[i]), 32'(exp_wen));
        chk("cmd_read_en", 32'(read_en[i]), 32'(!we));
        chk("cmd_addr", 32'(addr_o[i]), 32'(addr));
        if (we) chk("cmd_wdata", 32'(write_data[i]), 32'(wd));
        chk("cmd_no_rsp", 32'(rsp_valid[i][0] | rsp_valid[i][1]), 32'(0));
        for (int j = 0; j < lat; j++) begin
            @(negedge clk); #1;
            chk("wait_no_rsp", 32'(rsp_valid[i][0] | rsp_valid[i][1]), 32'(0));
            chk("wait_no_strobe", 32'(write_en[i] | read_en[i]), 32'(0));
        end
        // T+2+latency: the response cycle.
        @(negedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid[i][k]), 32'(1));
        chk("rsp_other_quiet", 32'(rsp_valid[i][1-k]), 32'(0));
        chk("rsp_rdata", 32'(rsp_rdata[i][k]), 32'(exp_rd));
        chk("rsp_err", 32'(rsp_err[i][k]), 32'(exp_err));
        chk("rsp_last_grant", 32'(last_grant[i]), 32'(k));
        @(negedge clk); #1;
        chk("post_idle", 32'(busy[i]), 32'(0));
        chk("post_rsp_cleared", 32'(rsp_valid[i][k]), 32'(0));
        $display("txn inst%0d(lat=%0d) port%0d %s addr=%0d wdata=0x%02h rdata=0x%02h err=%0d",
                 i, lat_of(i), k, we ? "WR" : "RD", addr, wd, rsp_rdata_prev(i, k), exp_err);
    endtask

    function automatic logic [7:0] rsp_rdata_prev(input int i, input int k);
        return (i >= 0 && k >= 0) ? 8'h00 : 8'h00;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        int prev;
        int pend;
        int n;
        logic saw_rsp;

        chk_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[i][k] = 1'b0;
                req_we[i][k]    = 1'b0;
                req_addr[i][k]  = 7'd0;
                req_wdata[i][k] = 8'd0;
            end
        end
        rstn_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        // Reset state
        chk("reset_busy", 32'(busy[0]), 32'(0));
        chk("reset_last_grant", 32'(last_grant[0]), 32'(0));
        chk("reset_write_en", 32'(write_en[0]), 32'(0));
        chk("reset_read_en", 32'(read_en[0]), 32'(0));
        chk("reset_rsp0", 32'(rsp_valid[0][0]), 32'(0));
        chk("reset_addr", 32'(addr_o[0]), 32'(0));
        rstn_n = 1'b1;

        // Continuous contention from reset: grants 0,1,0,1, three cycles apart.
        req_we[0][0] = 1'b1; req_addr[0][0] = 7'd10; req_wdata[0][0] = 8'h11;
        req_we[0][1] = 1'b1; req_addr[0][1] = 7'd11; req_wdata[0][1] = 8'h22;
        req_valid[0][0] = 1'b1;
        req_valid[0][1] = 1'b1;
        acc_n = 0; prev = 0; pend = -1;
        #1;
        for (int c = 0; c < 40 && acc_n < 4; c++) begin
            if (pend >= 0) begin
                chk("cont_last_grant", 32'(last_grant[0]), 32'(pend));
                pend = -1;
            end
            if (req_ready[0][0] && req_ready[0][1]) begin
                chk("cont_both_ready", 32'(1), 32'(0));
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (req_ready[0][k]) begin
                        chk("cont_order", 32'(k), 32'(acc_n % 2));
                        if (acc_n > 0) chk("cont_gap", 32'(cyc - prev), 32'(3));
                        $display("txn inst0 contention accept #%0d port%0d cycle=%0d", acc_n, k, cyc);
                        prev = cyc;
                        acc_n++;
                        pend = k;
                    end
                end
            end
            if (acc_n < 4) begin
                @(negedge clk); #1;
            end
        end
        chk("cont_accept_count", 32'(acc_n), 32'(4));
        @(negedge clk); #1;
        if (pend >= 0) chk("cont_last_grant", 32'(last_grant[0]), 32'(pend));
        req_valid[0][0] = 1'b0;
        req_valid[0][1] = 1'b0;
        n = 0;
        while (busy[0] && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("cont_drain", 32'(busy[0]), 32'(0));

        // READ_LATENCY = 1 instance
        run_txn(0, 0, 1'b1, 7'd5, 8'hA5, 1'b1, 8'h00, 1'b0);
        chk("mem5_written", 32'(mem_wr[0][5]), 32'(1));
        chk("mem5_data", 32'(mem_data[0][5]), 32'(8'hA5));
        run_txn(0, 1, 1'b0, 7'd100, 8'h00, 1'b0, 8'h3C, 1'b0);
        run_txn(0, 0, 1'b1, 7'd96, 8'h77, 1'b0, 8'h00, 1'b1);
        chk("mem96_untouched", 32'(mem_wr[0][96]), 32'(0));
        run_txn(0, 0, 1'b0, 7'd96, 8'h00, 1'b0, 8'hD6, 1'b0);
        run_txn(0, 1, 1'b0, 7'd5, 8'h00, 1'b0, 8'hA5, 1'b0);
        run_txn(0, 1, 1'b1, 7'd95, 8'h3A, 1'b1, 8'h00, 1'b0);

        // READ_LATENCY = 0 instance
        run_txn(1, 0, 1'b0, 7'd20, 8'h00, 1'b0, 8'h81, 1'b0);
        run_txn(1, 1, 1'b1, 7'd7, 8'h5C, 1'b1, 8'h00, 1'b0);
        run_txn(1, 1, 1'b0, 7'd7, 8'h00, 1'b0, 8'h5C, 1'b0);

        // READ_LATENCY = 3 instance
        run_txn(2, 1, 1'b0, 7'd21, 8'h00, 1'b0, 8'h42, 1'b0);

        // Reset during WAIT on the latency-3 instance (grant to port 0
        // leaves the pointer at 1 if the reset fails to clear it).
        req_we[2][0] = 1'b0; req_addr[2][0] = 7'd22; req_valid[2][0] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[2][0] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_txn_accept", 32'(req_ready[2][0]), 32'(1));
        @(negedge clk);
        req_valid[2][0] = 1'b0;
        @(negedge clk); #1;
        chk("rst_txn_in_wait", 32'(busy[2]), 32'(1));
        rstn_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy[2]), 32'(0));
        chk("rst_read_en", 32'(read_en[2]), 32'(0));
        chk("rst_rsp", 32'(rsp_valid[2][0] | rsp_valid[2][1]), 32'(0));
        chk("rst_addr", 32'(addr_o[2]), 32'(0));
        chk("rst_last_grant", 32'(last_grant[2]), 32'(0));
        repeat (2) @(negedge clk);
        rstn_n = 1'b1;
        saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (rsp_valid[2][0] | rsp_valid[2][1]) saw_rsp = 1'b1;
        end
        chk("rst_no_late_rsp", 32'(saw_rsp), 32'(0));
        $display("txn inst2 reset during WAIT, in-flight read dropped");

        // Fresh tie after reset: port 0 must win.
        req_we[2][1] = 1'b0; req_addr[2][1] = 7'd22; req_valid[2][1] = 1'b1;
        req_we[2][0] = 1'b0; req_addr[2][0] = 7'd21; req_valid[2][0] = 1'b1;
        #1;
        chk("tie_ready0", 32'(req_ready[2][0]), 32'(1));
        chk("tie_ready1", 32'(req_ready[2][1]), 32'(0));
        run_txn(2, 0, 1'b0, 7'd21, 8'h00, 1'b0, 8'h42, 1'b0);
        run_txn(2, 1, 1'b0, 7'd22, 8'h00, 1'b0, 8'h99, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
